bpred_update_sched: RTL and testbench

Controller that owns the single port of a branch-predictor counter table and sequences all accesses to it. It fills the table after reset, grants decode-stage lookups, and buffers execute-stage resolved outcomes in a small queue. Each outcome is applied as a read-modify-write saturating-counter update. It sits between the decode/execute pipeline stages and a single-port synchronous counter RAM.

---
 rtl/bpred_pkg.sv | 31 +++
 rtl/bpred_upd_fifo.sv | 54 +++++
 rtl/bpred_update_sched.sv | 149 ++++++++++++++
 tb/tb_bpred_update_sched.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bpred_pkg.sv
// Shared types and helpers for the branch-predictor counter table scheduler.
package bpred_pkg;

  localparam int IDX_W_DEF = 10;
  localparam int CTR_W_DEF = 2;
  localparam int CTR_MAX_W = 8;

  typedef enum logic [1:0] {
    INIT   = 2'd0,
    IDLE   = 2'd1,
    UPD_WR = 2'd2
  } state_t;

  typedef struct packed {
    logic [IDX_W_DEF-1:0] idx;
    logic                 taken;
  } upd_entry_t;

  // Counter width is carried by max_v so one helper serves any CTR_W up to CTR_MAX_W.
  function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] v,
                                                   input logic [CTR_MAX_W-1:0] max_v);
    if (v >= max_v) return max_v;
    else return v + 8'd1;
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] v);
    if (v == 8'd0) return 8'd0;
    else return v - 8'd1;
  endfunction

endpackage

// File: rtl/bpred_upd_fifo.sv
// Small synchronous FIFO holding resolved branch outcomes awaiting their read-modify-write.
module bpred_upd_fifo #(
  parameter int W     = 11,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               din,
  output logic [W-1:0]               dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [PW:0]   count_r;
  logic          push_s;
  logic          pop_s;

  assign full   = (count_r == (PW+1)'(DEPTH));
  assign empty  = (count_r == {(PW+1){1'b0}});
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;
  assign dout   = mem_r[rd_ptr_r];
  assign count  = count_r;

  // Entry storage; contents are meaningless until pushed, so no reset.
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + (PW+1)'(1);
        2'b01:   count_r <= count_r - (PW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bpred_update_sched.sv
// Owns the single counter-table port: init sweep, lookup grants and queued saturating RMW updates.
module bpred_update_sched
  import bpred_pkg::*;
#(
  parameter int IDX_W    = IDX_W_DEF,
  parameter int CTR_W    = CTR_W_DEF,
  parameter int DEPTH    = 4,
  parameter int INIT_VAL = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             lookup_valid,
  input  logic [IDX_W-1:0] lookup_idx,
  output logic             lookup_grant,
  input  logic             upd_valid,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  output logic             upd_ready,
  output logic             tbl_en,
  output logic             tbl_we,
  output logic [IDX_W-1:0] tbl_addr,
  output logic [CTR_W-1:0] tbl_wdata,
  input  logic [CTR_W-1:0] tbl_rdata,
  output logic             init_done,
  output logic             busy
);
  localparam int                   CNT_W     = $clog2(DEPTH) + 1;
  localparam logic [CTR_MAX_W-1:0] CTR_MAX_V = CTR_MAX_W'((1 << CTR_W) - 1);
  localparam logic [CTR_W-1:0]     INIT_V    = CTR_W'(INIT_VAL);
  localparam logic [IDX_W-1:0]     LAST_ADDR = {IDX_W{1'b1}};

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             taken;
  } entry_t;

  state_t           state_r;
  logic [IDX_W-1:0] init_addr_r;
  logic             init_done_r;
  entry_t           push_s;
  entry_t           head_s;
  logic [CNT_W-1:0] count_s;
  logic             full_s;
  logic             empty_s;
  logic             push_en_s;
  logic             pop_s;
  logic             issue_s;
  logic             grant_s;
  logic             en_s;
  logic             we_s;
  logic [IDX_W-1:0] addr_s;
  logic [CTR_W-1:0] wdata_s;

  assign upd_ready = init_done_r && (count_s < CNT_W'(DEPTH));
  assign push_en_s = upd_valid && upd_ready;
  assign push_s    = '{idx: upd_idx, taken: upd_taken};

  bpred_upd_fifo #(.W($bits(entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_en_s),
    .pop   (pop_s),
    .din   (push_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Port arbitration: a full queue beats lookups, otherwise lookups beat pending updates.
  always_comb begin
    grant_s = 1'b0;
    en_s    = 1'b0;
    we_s    = 1'b0;
    addr_s  = {IDX_W{1'b0}};
    wdata_s = {CTR_W{1'b0}};
    issue_s = 1'b0;
    pop_s   = 1'b0;
    case (state_r)
      INIT: begin
        en_s    = 1'b1;
        we_s    = 1'b1;
        addr_s  = init_addr_r;
        wdata_s = INIT_V;
      end
      IDLE: begin
        if (full_s || (!lookup_valid && !empty_s)) begin
          issue_s = 1'b1;
          en_s    = 1'b1;
          addr_s  = head_s.idx;
        end else if (lookup_valid) begin
          grant_s = 1'b1;
          en_s    = 1'b1;
          addr_s  = lookup_idx;
        end else begin
          en_s = 1'b0;
        end
      end
      UPD_WR: begin
        en_s   = 1'b1;
        we_s   = 1'b1;
        addr_s = head_s.idx;
        pop_s  = 1'b1;
        if (head_s.taken) wdata_s = CTR_W'(sat_inc(CTR_MAX_W'(tbl_rdata), CTR_MAX_V));
        else wdata_s = CTR_W'(sat_dec(CTR_MAX_W'(tbl_rdata)));
      end
      default: begin
        en_s = 1'b0;
      end
    endcase
  end

  // Reset silences the port immediately, abandoning any in-flight write.
  assign tbl_en       = en_s && rst_n;
  assign tbl_we       = we_s && rst_n;
  assign lookup_grant = grant_s && rst_n;
  assign tbl_addr     = addr_s;
  assign tbl_wdata    = wdata_s;
  assign init_done    = init_done_r;
  assign busy         = (state_r != IDLE) || !empty_s;

  // Scheduler FSM with init sweep counter and sticky init_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= INIT;
      init_addr_r <= {IDX_W{1'b0}};
      init_done_r <= 1'b0;
    end else begin
      case (state_r)
        INIT: begin
          init_addr_r <= init_addr_r + IDX_W'(1);
          if (init_addr_r == LAST_ADDR) begin
            state_r     <= IDLE;
            init_done_r <= 1'b1;
          end else begin
            state_r <= INIT;
          end
        end
        IDLE: begin
          if (issue_s) state_r <= UPD_WR;
          else state_r <= IDLE;
        end
        UPD_WR:  state_r <= IDLE;
        default: state_r <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bpred_update_sched.sv
// Directed table-driven bench for bpred_update_sched with a behavioural single-port counter RAM.
module tb_bpred_update_sched;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       lookup_valid;
  logic [3:0] lookup_idx;
  logic       lookup_grant;
  logic       upd_valid;
  logic [3:0] upd_idx;
  logic       upd_taken;
  logic       upd_ready;
  logic       tbl_en;
  logic       tbl_we;
  logic [3:0] tbl_addr;
  logic [1:0] tbl_wdata;
  logic [1:0] tbl_rdata;
  logic       init_done;
  logic       busy;

  int total = 0;
  int bad   = 0;

  logic [1:0] mem [16];

  typedef struct {
    logic       lv;
    logic [3:0] li;
    logic       uv;
    logic [3:0] ui;
    logic       ut;
    logic       g;
    logic       en;
    logic       we;
    logic [3:0] a;
    logic       rdy;
    logic       cw;
    logic [1:0] wd;
  } vec_t;

  vec_t vecs[$];

  bpred_update_sched #(.IDX_W(4), .CTR_W(2), .DEPTH(4), .INIT_VAL(1)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .lookup_valid (lookup_valid),
    .lookup_idx   (lookup_idx),
    .lookup_grant (lookup_grant),
    .upd_valid    (upd_valid),
    .upd_idx      (upd_idx),
    .upd_taken    (upd_taken),
    .upd_ready    (upd_ready),
    .tbl_en       (tbl_en),
    .tbl_we       (tbl_we),
    .tbl_addr     (tbl_addr),
    .tbl_wdata    (tbl_wdata),
    .tbl_rdata    (tbl_rdata),
    .init_done    (init_done),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  // Single-port synchronous counter RAM.
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else tbl_rdata <= mem[tbl_addr];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic lv, input logic [3:0] li, input logic uv, input logic [3:0] ui,
                     input logic ut, input logic g, input logic en, input logic we,
                     input logic [3:0] a, input logic rdy, input logic cw, input logic [1:0] wd);
    vec_t v;
    v = '{lv: lv, li: li, uv: uv, ui: ui, ut: ut, g: g, en: en, we: we, a: a,
          rdy: rdy, cw: cw, wd: wd};
    vecs.push_back(v);
  endtask

  task automatic drive(input logic lv, input logic [3:0] li, input logic uv,
                       input logic [3:0] ui, input logic ut);
    lookup_valid = lv;
    lookup_idx   = li;
    upd_valid    = uv;
    upd_idx      = ui;
    upd_taken    = ut;
  endtask

  task automatic check_init_sweep(input string tag);
    chk({tag, "_en0"}, 32'(tbl_en), 32'd1);
    chk({tag, "_we0"}, 32'(tbl_we), 32'd1);
    chk({tag, "_addr0"}, 32'(tbl_addr), 32'd0);
    chk({tag, "_rdy0"}, 32'(upd_ready), 32'd0);
    for (int k = 1; k < 16; k++) begin
      @(posedge clk);
      #4;
      chk($sformatf("%s_addr%0d", tag, k), 32'(tbl_addr), 32'(k));
      chk($sformatf("%s_wd%0d", tag, k), 32'(tbl_wdata), 32'd1);
      chk($sformatf("%s_we%0d", tag, k), 32'(tbl_we), 32'd1);
      chk($sformatf("%s_done%0d", tag, k), 32'(init_done), 32'd0);
      chk($sformatf("%s_rdy%0d", tag, k), 32'(upd_ready), 32'd0);
    end
    @(posedge clk);
    #4;
    chk({tag, "_done"}, 32'(init_done), 32'd1);
    chk({tag, "_rdy"}, 32'(upd_ready), 32'd1);
    chk({tag, "_idle_en"}, 32'(tbl_en), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);

    // Lookup priority with one queued entry.
    add(1'b1, 4'd5, 1'b1, 4'd9, 1'b1,  1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 2'd0);
    add(1'b1, 4'd5, 1'b0, 4'd0, 1'b0,  1'b1, 1'b1, 1'b0, 4'd5, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b0, 4'd9, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b1, 4'd9, 1'b1, 1'b1, 2'd2);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0);
    // Constant lookups and updates: fill, full wins, alternate; entry 3 saturates at 3.
    for (int i = 0; i < 4; i++)
      add(1'b1, 4'd2, 1'b1, 4'd3, 1'b1,  1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 2'd0);
    add(1'b1, 4'd2, 1'b1, 4'd3, 1'b1,  1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 2'd0);
    add(1'b1, 4'd2, 1'b1, 4'd3, 1'b1,  1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 2'd2);
    add(1'b1, 4'd2, 1'b1, 4'd3, 1'b1,  1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 2'd0);
    add(1'b1, 4'd2, 1'b1, 4'd3, 1'b1,  1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 2'd0);
    add(1'b1, 4'd2, 1'b1, 4'd3, 1'b1,  1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 2'd3);
    add(1'b1, 4'd2, 1'b1, 4'd3, 1'b1,  1'b1, 1'b1, 1'b0, 4'd2, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b0, 4'd3, 1'b0, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b1, 2'd3);
    for (int i = 0; i < 3; i++) begin
      add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0);
      add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 2'd3);
    end
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0);
    // Four not-taken outcomes on entry 3: 3->2->1->0->0.
    add(1'b0, 4'd0, 1'b1, 4'd3, 1'b0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b1, 4'd3, 1'b0,  1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b1, 4'd3, 1'b0,  1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 2'd2);
    add(1'b0, 4'd0, 1'b1, 4'd3, 1'b0,  1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 2'd1);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b1, 4'd3, 1'b1, 1'b1, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0);
    // Back-to-back taken updates to entry 7 must chain through the RAM.
    add(1'b0, 4'd0, 1'b1, 4'd7, 1'b1,  1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b1, 4'd7, 1'b1,  1'b0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 2'd2);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 2'd0);
    add(1'b0, 4'd0, 1'b0, 4'd0, 1'b0,  1'b0, 1'b1, 1'b1, 4'd7, 1'b1, 1'b1, 2'd3);
    add(1'b1, 4'd7, 1'b0, 4'd0, 1'b0,  1'b1, 1'b1, 1'b0, 4'd7, 1'b1, 1'b0, 2'd0);

    // Reset state.
    repeat (2) @(posedge clk);
    #4;
    chk("rst_en", 32'(tbl_en), 32'd0);
    chk("rst_grant", 32'(lookup_grant), 32'd0);
    chk("rst_ready", 32'(upd_ready), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    check_init_sweep("init");

    foreach (vecs[i]) begin
      @(posedge clk);
      #1 drive(vecs[i].lv, vecs[i].li, vecs[i].uv, vecs[i].ui, vecs[i].ut);
      #3;
      chk($sformatf("v%0d_grant", i), 32'(lookup_grant), 32'(vecs[i].g));
      chk($sformatf("v%0d_en", i), 32'(tbl_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_ready", i), 32'(upd_ready), 32'(vecs[i].rdy));
      if (vecs[i].en) begin
        chk($sformatf("v%0d_we", i), 32'(tbl_we), 32'(vecs[i].we));
        chk($sformatf("v%0d_addr", i), 32'(tbl_addr), 32'(vecs[i].a));
      end
      if (vecs[i].cw) chk($sformatf("v%0d_wdata", i), 32'(tbl_wdata), 32'(vecs[i].wd));
    end

    @(posedge clk);
    #1 drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    #3;
    chk("lookup7_rdata", 32'(tbl_rdata), 32'd3);
    chk("lookup7_en", 32'(tbl_en), 32'd0);

    // Reset during UPD_WR with three entries still queued.
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1 drive(1'b0, 4'd0, 1'b1, 4'd1, 1'b1);
    end
    @(posedge clk);
    #1 drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    #1;
    chk("mid_wr_we", 32'(tbl_we), 32'd1);
    chk("mid_wr_busy", 32'(busy), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_en", 32'(tbl_en), 32'd0);
    chk("mid_rst_ready", 32'(upd_ready), 32'd0);
    chk("mid_rst_done", 32'(init_done), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    #3;
    check_init_sweep("reinit");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
